// File: rtl/sb_ccff_loader_if.sv
// Handshake and chain signals between the bitstream fetch logic, the loader and
// the sb_x__y_ configuration chain.
`timescale 1ns/1ps

interface sb_ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              verify_en;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              mismatch;

    modport master (
        output start, verify_en, abort, cfg_data, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, ccff_shift, busy, done, aborted, mismatch
    );

    modport slave (
        input  start, verify_en, abort, cfg_data, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, ccff_shift, busy, done, aborted, mismatch
    );
endinterface

// File: rtl/sb_ccff_loader.sv
// Serialises bitstream words MSB-first into one switch-block ccff chain, with an
// optional second pass that checks the chain's tail output against the resent stream.
`timescale 1ns/1ps

module sb_ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input logic             prog_clk,
    input logic             pReset,
    sb_ccff_loader_if.slave bus
);
    localparam int NWORDS = CHAIN_LEN / WORD_W;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WBIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WCNT_W = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(NWORDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    if (CHAIN_LEN % WORD_W != 0) begin : g_len_check
        $error("sb_ccff_loader: CHAIN_LEN must be a multiple of WORD_W");
    end

    logic [1:0]        state;
    logic              verify_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [WORD_W-1:0] sreg;
    logic              active;
    logic [WBIT_W-1:0] wbit;
    logic              aborted_q;
    logic              mismatch_q;

    logic busy;
    logic ready;
    logic accept;
    logic last_shift;

    assign busy       = (state == ST_LOAD) || (state == ST_VERIFY);
    // Ready on the final bit of the current word so the next word shifts without a bubble.
    assign ready      = busy && (word_cnt != WCNT_FULL) && (!active || (wbit == WBIT_LAST));
    assign accept     = ready && bus.cfg_valid;
    assign last_shift = active && (bit_cnt == BIT_LAST);

    assign bus.cfg_ready  = ready;
    assign bus.ccff_shift = active;
    assign bus.ccff_head  = active & sreg[WORD_W-1];
    assign bus.busy       = busy;
    assign bus.done       = (state == ST_DONE);
    assign bus.aborted    = aborted_q;
    assign bus.mismatch   = mismatch_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state      <= ST_IDLE;
            verify_q   <= 1'b0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            sreg       <= '0;
            active     <= 1'b0;
            wbit       <= '0;
            aborted_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_LOAD;
                        verify_q   <= bus.verify_en;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                ST_LOAD, ST_VERIFY: begin
                    if (bus.abort) begin
                        state     <= ST_IDLE;
                        active    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else begin
                        if (active) begin
                            sreg    <= sreg << 1;
                            wbit    <= wbit + 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (wbit == WBIT_LAST)
                                active <= 1'b0;
                            // Tail still shows the bit loaded on the first pass at this position.
                            if ((state == ST_VERIFY) && (bus.ccff_tail != sreg[WORD_W-1]))
                                mismatch_q <= 1'b1;
                        end
                        if (accept) begin
                            sreg     <= bus.cfg_data;
                            active   <= 1'b1;
                            wbit     <= '0;
                            word_cnt <= word_cnt + 1'b1;
                        end
                        if (last_shift) begin
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                            state    <= ((state == ST_LOAD) && verify_q) ? ST_VERIFY : ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sb_ccff_loader.sv
// Scoreboard bench for sb_ccff_loader against a 64-bit shift-register chain model.
`timescale 1ns/1ps

module tb_sb_ccff_loader;
    logic prog_clk = 1'b0;
    logic pReset   = 1'b1;
    logic [63:0] chain = '0;

    always #5 prog_clk = ~prog_clk;

    sb_ccff_loader_if #(.WORD_W(8)) ifc ();

    sb_ccff_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (ifc.slave)
    );

    always @(posedge prog_clk)
        if (ifc.ccff_shift) chain <= {chain[62:0], ifc.ccff_head};
    assign ifc.ccff_tail = chain[63];

    typedef struct {
        bit          is_abort;
        bit          mism;
        int          shifts;
        logic [63:0] chain;
        bit          contig;
    } sess_t;

    sess_t sess_q[$];
    bit    exp_bits[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] wsel(input logic [63:0] s, input int i);
        return s[63-8*i -: 8];
    endfunction

    // Monitor: consumes expected head bits and session outcomes as the DUT presents them.
    int mon_cyc = 0, first_shift = 0, last_shift = 0, sess_shifts = 0;
    bit prev_done = 1'b0;

    always @(negedge prog_clk) begin
        if (mon_en && !pReset) begin
            sess_t r;
            mon_cyc++;
            if (ifc.ccff_shift) begin
                if (sess_shifts == 0) first_shift = mon_cyc;
                last_shift = mon_cyc;
                sess_shifts++;
                chk("shift_expected", exp_bits.size() != 0, 1);
                if (exp_bits.size() != 0) chk("head_bit", ifc.ccff_head, exp_bits.pop_front());
            end
            if (prev_done) chk("done_width", ifc.done, 0);
            prev_done = ifc.done;
            if (ifc.done || ifc.aborted) begin
                chk("session_expected", sess_q.size() != 0, 1);
                if (sess_q.size() != 0) begin
                    r = sess_q.pop_front();
                    chk("end_kind_abort", ifc.aborted, r.is_abort);
                    chk("end_kind_done", ifc.done, !r.is_abort);
                    if (ifc.done) begin
                        chk("mismatch_at_done", ifc.mismatch, r.mism);
                        chk("shift_count", sess_shifts, r.shifts);
                        chk("chain_contents", chain, r.chain);
                        chk("done_latency", mon_cyc - last_shift, 1);
                        chk("busy_at_done", ifc.busy, 0);
                        chk("bits_drained", exp_bits.size(), 0);
                        if (r.contig) chk("contiguous_shifts", last_shift - first_shift + 1, r.shifts);
                    end
                end
                exp_bits.delete();
                sess_shifts = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge prog_clk);
        #1;
    endtask

    task automatic run_session(input bit ver, input logic [63:0] p1, input logic [63:0] p2,
                               input bit rnd, input int abort_after, input bit extra,
                               input bit start_mid);
        sess_t r;
        int    i = 0, nacc = 0, cyc = 0, shifts = 0;
        int    total, offered;
        bit    fin = 1'b0, acc;
        logic [7:0] w;

        total      = ver ? 16 : 8;
        offered    = total + (extra ? 1 : 0);
        r.is_abort = (abort_after > 0);
        r.mism     = ver && (p1 != p2);
        r.shifts   = total * 8;
        r.chain    = ver ? p2 : p1;
        r.contig   = !rnd;
        sess_q.push_back(r);

        ifc.start = 1'b1;
        ifc.verify_en = ver;
        idle(1);
        ifc.start = 1'b0;
        ifc.verify_en = $urandom_range(0, 1);
        chk("busy_after_start", ifc.busy, 1);
        chk("mismatch_cleared", ifc.mismatch, 0);

        while (!fin && cyc < 3000) begin
            ifc.cfg_valid = (i < offered) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            ifc.cfg_data  = (i < 8) ? wsel(p1, i) : (ver && i < 16) ? wsel(p2, i - 8) : 8'h3C;
            ifc.start     = start_mid && (cyc == 10);
            ifc.verify_en = ifc.start;
            ifc.abort     = (abort_after > 0) && (shifts >= abort_after);
            @(negedge prog_clk);
            acc = ifc.cfg_valid && ifc.cfg_ready;
            if (ifc.ccff_shift) shifts++;
            if (ifc.done) fin = 1'b1;
            @(posedge prog_clk);
            #1;
            if (ifc.abort) begin
                fin = 1'b1;
            end else if (acc) begin
                w = ifc.cfg_data;
                for (int b = 7; b >= 0; b--) exp_bits.push_back(w[b]);
                i++;
                nacc++;
            end
            cyc++;
        end
        ifc.cfg_valid = 1'b0;
        ifc.abort = 1'b0;
        ifc.start = 1'b0;
        chk("session_finished", fin, 1);
        if (abort_after > 0) begin
            @(negedge prog_clk);
            chk("aborted_pulse", ifc.aborted, 1);
            chk("after_abort_shift_ready_busy", {ifc.ccff_shift, ifc.cfg_ready, ifc.busy}, 0);
            idle(10);
        end else begin
            chk("words_accepted", nacc, total);
            idle(5);
            chk("mismatch_sticky", ifc.mismatch, r.mism);
            chk("idle_ready_low", ifc.cfg_ready, 0);
        end
    endtask

    initial begin
        logic [63:0] a, b;
        ifc.start = 1'b0;
        ifc.verify_en = 1'b0;
        ifc.abort = 1'b0;
        ifc.cfg_data = '0;
        ifc.cfg_valid = 1'b0;

        idle(2);
        chk("reset_outputs", {ifc.cfg_ready, ifc.ccff_head, ifc.ccff_shift, ifc.busy,
                              ifc.done, ifc.aborted, ifc.mismatch}, 0);
        pReset = 1'b0;
        idle(1);
        ifc.start = 1'b1;
        idle(1);
        ifc.start = 1'b0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_data = 8'hFF;
        idle(12);
        chk("pre_reset_busy", ifc.busy, 1);
        pReset = 1'b1;
        idle(1);
        chk("mid_reset_outputs", {ifc.cfg_ready, ifc.ccff_head, ifc.ccff_shift, ifc.busy,
                                  ifc.done, ifc.aborted, ifc.mismatch}, 0);
        idle(1);
        pReset = 1'b0;
        ifc.cfg_valid = 1'b0;
        chk("post_reset_outputs", {ifc.cfg_ready, ifc.ccff_head, ifc.ccff_shift, ifc.busy,
                                   ifc.done, ifc.aborted, ifc.mismatch}, 0);
        mon_en = 1'b1;
        idle(1);

        a = 64'hA53C960FF069C35C;
        run_session(1'b0, a, a, 1'b0, 0, 1'b0, 1'b0);

        a = {$urandom, $urandom};
        run_session(1'b1, a, a, 1'b1, 0, 1'b0, 1'b0);

        a = {$urandom, $urandom};
        a[39:32] = 8'($urandom_range(0, 254));
        b = a;
        b[39:32] = 8'hFF;
        run_session(1'b1, a, b, 1'b1, 0, 1'b0, 1'b0);

        run_session(1'b0, a, a, 1'b0, 20, 1'b0, 1'b0);

        a = {$urandom, $urandom};
        run_session(1'b0, a, a, 1'b0, 0, 1'b1, 1'b1);

        for (int n = 0; n < 4; n++) begin
            a = {$urandom, $urandom};
            b = a;
            if ($urandom_range(0, 1) == 1) b[$urandom_range(0, 63)] ^= 1'b1;
            run_session(1'($urandom_range(0, 1)), a, b, 1'b1, 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("sessions_drained", sess_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
